// File: rtl/pkt_router_pkg.sv
// pkt_router_pkg: shared sizes, address map, reset values and state type for the routing-table config block
package pkt_router_pkg;
  localparam int NUM_ENTRIES = 16;
  localparam int KEY_BITS = 32;
  localparam int ROUTE_BITS = 3;
  localparam logic [1:0] REGION_KEY = 2'b00;
  localparam logic [1:0] REGION_MASK = 2'b01;
  localparam logic [1:0] REGION_ROUTE = 2'b10;
  localparam logic [1:0] REGION_CTRL = 2'b11;
  localparam logic [7:0] CTRL_ADDR = 8'hC0;
  localparam logic [7:0] STATUS_ADDR = 8'hC1;
  localparam logic [7:0] PKT_COUNT_ADDR = 8'hC2;
  localparam logic [KEY_BITS-1:0] KEY_RST = '1;
  localparam logic [KEY_BITS-1:0] MASK_RST = '0;
  typedef enum logic {IDLE, PENDING} cfg_state_t;
endpackage

// File: rtl/pkt_router_cfg_regfile.sv
// pkt_router_cfg_regfile: shadow key/mask/route table with a bus write port and a registered read port
module pkt_router_cfg_regfile
  import pkt_router_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 i_wr,
  input  logic                                 i_rd,
  input  logic [7:0]                           i_addr,
  input  logic [31:0]                          i_wdata,
  input  logic [31:0]                          i_ctrl_rdata,
  output logic [NUM_ENTRIES-1:0][KEY_BITS-1:0] o_key,
  output logic [NUM_ENTRIES-1:0][KEY_BITS-1:0] o_mask,
  output logic [NUM_ENTRIES-1:0][ROUTE_BITS-1:0] o_route,
  output logic [31:0]                          o_rdata,
  output logic                                 o_rvld
);
  logic [NUM_ENTRIES-1:0][KEY_BITS-1:0] r_key;
  logic [NUM_ENTRIES-1:0][KEY_BITS-1:0] r_mask;
  logic [NUM_ENTRIES-1:0][ROUTE_BITS-1:0] r_route;
  logic [31:0] r_rdata;
  logic r_rvld;
  logic [3:0] w_idx;
  logic w_hit;
  logic [31:0] w_rdata;

  assign w_idx = i_addr[3:0];
  assign w_hit = (i_addr[5:4] == 2'b00) && ({1'b0, w_idx} < 5'(NUM_ENTRIES));
  assign w_rdata = !w_hit ? '0 :
                   i_addr[7:6] == REGION_KEY ? r_key[w_idx] :
                   i_addr[7:6] == REGION_MASK ? r_mask[w_idx] :
                   i_addr[7:6] == REGION_ROUTE ? 32'(r_route[w_idx]) : i_ctrl_rdata;
  assign o_key = r_key;
  assign o_mask = r_mask;
  assign o_route = r_route;
  assign o_rdata = r_rdata;
  assign o_rvld = r_rvld;

  // shadow table: accepted bus writes land at the acceptance edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_key <= {NUM_ENTRIES{KEY_RST}};
      r_mask <= {NUM_ENTRIES{MASK_RST}};
      r_route <= '0;
    end else if (i_wr && w_hit) begin
      if (i_addr[7:6] == REGION_KEY) r_key[w_idx] <= i_wdata;
      if (i_addr[7:6] == REGION_MASK) r_mask[w_idx] <= i_wdata;
      if (i_addr[7:6] == REGION_ROUTE) r_route[w_idx] <= i_wdata[ROUTE_BITS-1:0];
    end

  // registered read port: data and a one-cycle valid pulse after acceptance
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rdata <= '0;
      r_rvld <= 1'b0;
    end else begin
      r_rdata <= i_rd ? w_rdata : '0;
      r_rvld <= i_rd;
    end
endmodule

// File: rtl/pkt_router_cfg.sv
// pkt_router_cfg: shadow/active routing table controller with packet-safe commit and transfer counter
module pkt_router_cfg
  import pkt_router_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [7:0]                             cfg_addr_in,
  input  logic [31:0]                            cfg_wdata_in,
  input  logic                                   cfg_wr_in,
  input  logic                                   cfg_rd_in,
  output logic                                   cfg_rdy_out,
  output logic [31:0]                            cfg_rdata_out,
  output logic                                   cfg_rvld_out,
  input  logic                                   pkt_vld_in,
  input  logic                                   pkt_rdy_in,
  output logic [NUM_ENTRIES-1:0][KEY_BITS-1:0]   reg_key_out,
  output logic [NUM_ENTRIES-1:0][KEY_BITS-1:0]   reg_mask_out,
  output logic [NUM_ENTRIES-1:0][ROUTE_BITS-1:0] reg_route_out
);
  cfg_state_t r_state, w_state_nxt;
  logic [NUM_ENTRIES-1:0][KEY_BITS-1:0] r_act_key, r_act_mask, w_sh_key, w_sh_mask;
  logic [NUM_ENTRIES-1:0][ROUTE_BITS-1:0] r_act_route, w_sh_route;
  logic [31:0] r_count;
  logic [31:0] w_ctrl_rdata;
  logic w_acc_wr, w_acc_rd, w_xfer, w_safe, w_commit, w_clr, w_req_commit;

  assign cfg_rdy_out = r_state == IDLE;
  assign w_acc_wr = cfg_wr_in && cfg_rdy_out;
  assign w_acc_rd = cfg_rd_in && !cfg_wr_in && cfg_rdy_out;
  assign w_xfer = pkt_vld_in && pkt_rdy_in;
  assign w_safe = !pkt_vld_in || pkt_rdy_in;
  assign w_commit = (r_state == PENDING) && w_safe;
  assign w_clr = w_acc_wr && cfg_addr_in == PKT_COUNT_ADDR;
  assign w_req_commit = w_acc_wr && cfg_addr_in == CTRL_ADDR && cfg_wdata_in[0];
  assign w_ctrl_rdata = cfg_addr_in == STATUS_ADDR ? {31'b0, r_state == PENDING} :
                        cfg_addr_in == PKT_COUNT_ADDR ? r_count : '0;
  assign reg_key_out = r_act_key;
  assign reg_mask_out = r_act_mask;
  assign reg_route_out = r_act_route;

  pkt_router_cfg_regfile u_regfile (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_wr         (w_acc_wr),
    .i_rd         (w_acc_rd),
    .i_addr       (cfg_addr_in),
    .i_wdata      (cfg_wdata_in),
    .i_ctrl_rdata (w_ctrl_rdata),
    .o_key        (w_sh_key),
    .o_mask       (w_sh_mask),
    .o_route      (w_sh_route),
    .o_rdata      (cfg_rdata_out),
    .o_rvld       (cfg_rvld_out)
  );

  // commit FSM next state: a request waits in PENDING until a cycle with no stalled packet
  always_comb begin
    w_state_nxt = w_commit ? IDLE : (r_state == IDLE && w_req_commit) ? PENDING : r_state;
  end

  // commit FSM state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_state_nxt;

  // active table: whole-table copy from shadow on a commit-safe edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_act_key <= {NUM_ENTRIES{KEY_RST}};
      r_act_mask <= {NUM_ENTRIES{MASK_RST}};
      r_act_route <= '0;
    end else if (w_commit) begin
      r_act_key <= w_sh_key;
      r_act_mask <= w_sh_mask;
      r_act_route <= w_sh_route;
    end

  // transfer counter: wraps naturally, clear write beats a same-cycle transfer
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_count <= '0;
    else if (w_clr) r_count <= '0;
    else if (w_xfer) r_count <= r_count + 32'd1;
endmodule

// File: tb/tb_pkt_router_cfg.sv
// tb_pkt_router_cfg: directed and randomized checks against a transaction-level table model
module tb_pkt_router_cfg;
  import pkt_router_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] cfg_addr_in = '0;
  logic [31:0] cfg_wdata_in = '0;
  logic cfg_wr_in = 1'b0;
  logic cfg_rd_in = 1'b0;
  logic cfg_rdy_out;
  logic [31:0] cfg_rdata_out;
  logic cfg_rvld_out;
  logic pkt_vld_in = 1'b0;
  logic pkt_rdy_in = 1'b0;
  logic [NUM_ENTRIES-1:0][KEY_BITS-1:0] reg_key_out;
  logic [NUM_ENTRIES-1:0][KEY_BITS-1:0] reg_mask_out;
  logic [NUM_ENTRIES-1:0][ROUTE_BITS-1:0] reg_route_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] s_key[NUM_ENTRIES], s_mask[NUM_ENTRIES], s_route[NUM_ENTRIES];
  logic [31:0] a_key[NUM_ENTRIES], a_mask[NUM_ENTRIES], a_route[NUM_ENTRIES];
  logic [31:0] m_cnt;
  bit m_pend;

  pkt_router_cfg dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_addr_in   (cfg_addr_in),
    .cfg_wdata_in  (cfg_wdata_in),
    .cfg_wr_in     (cfg_wr_in),
    .cfg_rd_in     (cfg_rd_in),
    .cfg_rdy_out   (cfg_rdy_out),
    .cfg_rdata_out (cfg_rdata_out),
    .cfg_rvld_out  (cfg_rvld_out),
    .pkt_vld_in    (pkt_vld_in),
    .pkt_rdy_in    (pkt_rdy_in),
    .reg_key_out   (reg_key_out),
    .reg_mask_out  (reg_mask_out),
    .reg_route_out (reg_route_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      s_key[i] = 32'hFFFF_FFFF; s_mask[i] = 0; s_route[i] = 0;
      a_key[i] = 32'hFFFF_FFFF; a_mask[i] = 0; a_route[i] = 0;
    end
    m_cnt = 0;
    m_pend = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a[5:4] != 2'b00) return 32'h0;
    case (a[7:6])
      2'd0: return s_key[a[3:0]];
      2'd1: return s_mask[a[3:0]];
      2'd2: return s_route[a[3:0]];
      default: return a == 8'hC1 ? {31'b0, m_pend} : a == 8'hC2 ? m_cnt : 32'h0;
    endcase
  endfunction

  // apply this cycle's effects to the model, advance one clock, then compare bus outputs
  task automatic tick();
    bit acc_wr, acc_rd;
    logic [7:0] a;
    logic [31:0] rv;
    a = cfg_addr_in;
    acc_wr = cfg_wr_in && !m_pend;
    acc_rd = cfg_rd_in && !cfg_wr_in && !m_pend;
    rv = m_read(a);
    if (acc_wr && a == 8'hC2) m_cnt = 0;
    else if (pkt_vld_in && pkt_rdy_in) m_cnt = m_cnt + 1;
    if (m_pend) begin
      if (!pkt_vld_in || pkt_rdy_in) begin
        a_key = s_key; a_mask = s_mask; a_route = s_route;
        m_pend = 0;
      end
    end else if (acc_wr && a[5:4] == 2'b00) begin
      case (a[7:6])
        2'd0: s_key[a[3:0]] = cfg_wdata_in;
        2'd1: s_mask[a[3:0]] = cfg_wdata_in;
        2'd2: s_route[a[3:0]] = 32'(cfg_wdata_in[ROUTE_BITS-1:0]);
        default: if (a == 8'hC0 && cfg_wdata_in[0]) m_pend = 1;
      endcase
    end
    @(posedge clk);
    #1;
    chk("rdy", {31'b0, cfg_rdy_out}, {31'b0, !m_pend});
    chk("rvld", {31'b0, cfg_rvld_out}, {31'b0, acc_rd});
    if (acc_rd) chk("rdata", cfg_rdata_out, rv);
  endtask

  task automatic op(input bit w, input bit r, input logic [7:0] a, input logic [31:0] d);
    cfg_wr_in = w; cfg_rd_in = r; cfg_addr_in = a; cfg_wdata_in = d;
    tick();
    cfg_wr_in = 0; cfg_rd_in = 0;
  endtask

  task automatic chk_active();
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      chk("act_key", reg_key_out[i], a_key[i]);
      chk("act_mask", reg_mask_out[i], a_mask[i]);
      chk("act_route", 32'(reg_route_out[i]), a_route[i]);
    end
  endtask

  initial begin
    model_reset();
    #22 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_active();
    chk("rst_rdy", {31'b0, cfg_rdy_out}, 32'h1);
    chk("rst_rvld", {31'b0, cfg_rvld_out}, 32'h0);
    chk("rst_rdata", cfg_rdata_out, 32'h0);
    op(0, 1, 8'hC1, 0);
    chk("status_rst", cfg_rdata_out, 32'h0);
    tick();
    op(1, 0, 8'h03, 32'h0000_1200);
    op(1, 0, 8'h43, 32'hFFFF_FF00);
    op(1, 0, 8'h83, 32'h5);
    chk_active();
    op(1, 0, 8'hC0, 32'h1);
    chk("rdy_pend", {31'b0, cfg_rdy_out}, 32'h0);
    chk_active();
    tick();
    chk("key3", reg_key_out[3], 32'h0000_1200);
    chk("mask3", reg_mask_out[3], 32'hFFFF_FF00);
    chk("route3", 32'(reg_route_out[3]), 32'h5);
    chk("rdy_back", {31'b0, cfg_rdy_out}, 32'h1);
    op(1, 0, 8'h03, 32'hABCD_0000);
    pkt_vld_in = 1; pkt_rdy_in = 0;
    repeat (10) tick();
    op(1, 0, 8'hC0, 32'h1);
    cfg_rd_in = 1; cfg_addr_in = 8'hC1;
    repeat (10) tick();
    chk_active();
    chk("key3_held", reg_key_out[3], 32'h0000_1200);
    pkt_rdy_in = 1;
    tick();
    chk("key3_commit", reg_key_out[3], 32'hABCD_0000);
    tick();
    chk("status_after", cfg_rdata_out, 32'h0);
    cfg_rd_in = 0; pkt_vld_in = 0; pkt_rdy_in = 0;
    tick();
    op(1, 0, 8'hC2, 0);
    pkt_vld_in = 1; pkt_rdy_in = 1;
    repeat (7) tick();
    pkt_vld_in = 0;
    op(0, 1, 8'hC2, 0);
    chk("count7", cfg_rdata_out, 32'd7);
    pkt_vld_in = 1;
    op(1, 0, 8'hC2, 0);
    pkt_vld_in = 0;
    op(0, 1, 8'hC2, 0);
    chk("count_clr", cfg_rdata_out, 32'h0);
    force dut.r_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_count;
    m_cnt = 32'hFFFF_FFFF;
    op(0, 1, 8'hC2, 0);
    chk("count_max", cfg_rdata_out, 32'hFFFF_FFFF);
    pkt_vld_in = 1;
    tick();
    pkt_vld_in = 0;
    op(0, 1, 8'hC2, 0);
    chk("count_wrap", cfg_rdata_out, 32'h0);
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 9);
      cfg_addr_in = r < 6 ? {2'($urandom_range(0, 2)), 2'b00, 4'($urandom)} :
                    r < 8 ? 8'hC0 + 8'($urandom_range(0, 3)) : 8'($urandom);
      cfg_wdata_in = $urandom;
      cfg_wr_in = $urandom_range(0, 3) == 0;
      cfg_rd_in = $urandom_range(0, 2) == 0;
      pkt_vld_in = 1'($urandom_range(0, 1));
      pkt_rdy_in = 1'($urandom_range(0, 1));
      tick();
      if (n % 32 == 31) chk_active();
    end
    cfg_wr_in = 0; cfg_rd_in = 0; pkt_vld_in = 0; pkt_rdy_in = 0;
    tick();
    tick();
    chk_active();
    pkt_vld_in = 1; pkt_rdy_in = 0;
    op(1, 0, 8'h05, 32'h55);
    op(1, 0, 8'hC0, 32'h1);
    chk("pend_before_rst", {31'b0, cfg_rdy_out}, 32'h0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rdy_async", {31'b0, cfg_rdy_out}, 32'h1);
    chk("rst_rvld_async", {31'b0, cfg_rvld_out}, 32'h0);
    chk_active();
    #2 reset_n = 1'b1;
    pkt_vld_in = 0;
    op(0, 1, 8'hC1, 0);
    chk("status_post_rst", cfg_rdata_out, 32'h0);
    op(0, 1, 8'h05, 0);
    chk("shadow_key5_rst", cfg_rdata_out, 32'hFFFF_FFFF);
    op(1, 0, 8'h82, 32'hFF);
    op(0, 1, 8'h82, 0);
    chk("route2_trunc", cfg_rdata_out, 32'h7);
    op(0, 1, 8'h35, 0);
    chk("unmapped", cfg_rdata_out, 32'h0);
    tick();
    chk_active();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pkt_router_cfg.md
Name: pkt_router_cfg

Overview:
- Configuration controller for the 16-entry ternary routing table of the HSSL packet router.
- Holds a shadow copy and an active copy of the key/mask/route table. Software writes the shadow copy over a simple register bus.
- A commit copies shadow to active atomically, only in a cycle where it cannot change the route of a packet already being offered.
- Counts transferred packets. Sits between the board register bus and the router's table inputs.

Parameters:
- NUM_ENTRIES, 16, routing table entries (max 16, addressed by cfg_addr[3:0])
- ROUTE_BITS, 3, width of each route field

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_addr_in  in  8  register address
- cfg_wdata_in  in  32  write data
- cfg_wr_in  in  1  write request
- cfg_rd_in  in  1  read request
- cfg_rdy_out  out  1  bus ready; a request is accepted when (wr|rd) && rdy
- cfg_rdata_out  out  32  read data
- cfg_rvld_out  out  1  read data valid, one-cycle pulse
- pkt_vld_in  in  1  router input valid (monitor)
- pkt_rdy_in  in  1  router input ready (monitor)
- reg_key_out  out  32 x NUM_ENTRIES  active keys
- reg_mask_out  out  32 x NUM_ENTRIES  active masks
- reg_route_out  out  ROUTE_BITS x NUM_ENTRIES  active routes

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (reset_n).
- Reset values:
  - active and shadow key = 0xFFFF_FFFF, mask = 0, route = 0. No packet can hit any entry.
  - cfg_rdy_out = 1, cfg_rvld_out = 0, cfg_rdata_out = 0, packet count = 0, state = IDLE.
- Address map (cfg_addr[7:6] selects, [3:0] = entry e; [5:4] must be 0, else unmapped):
  - 00: shadow key[e]
  - 01: shadow mask[e]
  - 10: shadow route[e]. Writes use wdata[ROUTE_BITS-1:0]; reads zero-extend.
  - 11: control. 0xC0 CTRL: write bit0 = 1 requests commit. 0xC1 STATUS: bit0 = commit pending, read-only. 0xC2 PKT_COUNT: read returns count; any write clears it.
- Unmapped or e >= NUM_ENTRIES: writes ignored, reads return 0 with normal rvld.
- Write: takes effect at the clock edge of acceptance; the new shadow value is visible from the next cycle.
- Read: registered. rdata/rvld are asserted the cycle after acceptance, for exactly one cycle. Reads return shadow values, never active values.
- wr and rd asserted together: the write is performed, the read is ignored, no rvld.
- FSM IDLE / PENDING:
  - IDLE: accepted CTRL write with bit0 = 1 -> PENDING. cfg_rdy_out = 1.
  - PENDING: cfg_rdy_out = 0, so all bus requests stall. A commit-safe cycle is !pkt_vld_in || (pkt_vld_in && pkt_rdy_in). In a commit-safe cycle, all active entries take their shadow values at the edge, and the FSM -> IDLE.
  - If the commit request is accepted in a cycle that is itself safe, the commit still occurs no earlier than the following cycle. Minimum latency from CTRL write to active update is 1 cycle.
  - Commit never happens while vld = 1 and rdy = 0. Under a permanent stall the FSM stays PENDING indefinitely, with no timeout.
- Packet counter: 32-bit, increments on every pkt_vld_in && pkt_rdy_in cycle and wraps 0xFFFF_FFFF -> 0. A clear write in the same cycle as a transfer leaves the count at 0 (clear wins).
- Reset mid-commit: all state returns to reset values and the pending commit is lost.

Decomposition:
- Shared package pkt_router_pkg:
  - NUM_ENTRIES, KEY_BITS = 32, ROUTE_BITS
  - address-field constants (REGION_KEY/MASK/ROUTE/CTRL, CTRL_ADDR, STATUS_ADDR, PKT_COUNT_ADDR)
  - typedef cfg_state_t {IDLE, PENDING}
  - reset constants KEY_RST = '1, MASK_RST = '0
- One natural sub-module: pkt_router_cfg_regfile, holding the shadow table with a write port and a registered read port. The FSM, active copy and counter stay at top level.

Test Plan:
- Reset -> all reg_key_out = 0xFFFF_FFFF, masks 0, routes 0; read 0xC1 returns 0; rvld exactly 1 cycle after the read.
- Write key[3] = 0x0000_1200, mask[3] = 0xFFFF_FF00, route[3] = 5, with pkt_vld = 0 -> active entry unchanged. CTRL = 1 -> active[3] = {0x1200, 0xFFFF_FF00, 5} 1 cycle later; cfg_rdy low for exactly 1 cycle.
- Hold pkt_vld = 1, pkt_rdy = 0 for 10 cycles, then issue a commit -> active unchanged and STATUS read stalls (rdy = 0) throughout. Raise pkt_rdy -> commit at that edge; the next STATUS read returns 0.
- 7 handshakes, then read 0xC2 -> 7. Write 0xC2 in the same cycle as a handshake -> next read returns 0.
- Preload count to 0xFFFF_FFFF via 2^32-1 forced transfers (or a backdoor) plus one transfer -> 0.
- Assert reset_n low while PENDING -> shadow and active return to reset values, STATUS = 0, cfg_rdy = 1 immediately (asynchronous). Write route[2] = 0xFF -> reads back 7. Read address 0x35 -> 0.
